// File: rtl/alu_disp_scan.sv
// Sequential 4-op ALU whose result is converted to BCD by double-dabble and
// shown on a scanned, active-low-select 7-segment display.
module alu_disp_scan #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [1:0]        op,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              zero,
  output logic              error,
  output logic [DIGITS-1:0] select_disp,
  output logic [6:0]        seg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] CONV = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int RW = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(RW + 1);
  localparam int PW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned MAX_VAL = (DIGITS == 1) ? 9 :
                                    (DIGITS == 2) ? 99 :
                                    (DIGITS == 3) ? 999 : 9999;

  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic [RW-1:0]    bin_r;
  logic [BW-1:0]    bcd_r;
  logic [BW-1:0]    bcd_adj;
  logic [CW-1:0]    cnt;
  logic             err_r;
  logic [BW-1:0]    disp;

  logic [RW-1:0]    ax;
  logic [RW-1:0]    bx;
  logic [RW-1:0]    raw;
  logic             calc_bad;
  logic [RW-1:0]    calc_res;

  logic [PW-1:0]    pre;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_next;
  logic [3:0]       digit;
  logic [6:0]       seg_next;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    ax       = {{WIDTH{1'b0}}, a_r};
    bx       = {{WIDTH{1'b0}}, b_r};
    raw      = '0;
    calc_bad = 1'b0;
    case (op_r)
      2'b00: raw = ax + bx;
      2'b01: begin
        if (a_r < b_r) calc_bad = 1'b1;
        else           raw = ax - bx;
      end
      2'b10: raw = ax * bx;
      default: begin
        if (b_r == '0) calc_bad = 1'b1;
        else           raw = ax / bx;
      end
    endcase
    if ({{(32-RW){1'b0}}, raw} > MAX_VAL) calc_bad = 1'b1;
    calc_res = calc_bad ? '0 : raw;
  end

  always_comb begin
    bcd_adj = add3(bcd_r);
  end

  // CONV spends 2*WIDTH cycles shifting plus one closing cycle in which the
  // finished BCD is committed; DONE is therefore the cycle the display is new.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
      bin_r <= '0;
      bcd_r <= '0;
      cnt   <= '0;
      err_r <= 1'b0;
      disp  <= '0;
      zero  <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= in1;
            b_r   <= in2;
            op_r  <= op;
            state <= CALC;
          end
        end
        CALC: begin
          bin_r <= calc_res;
          err_r <= calc_bad;
          bcd_r <= '0;
          cnt   <= '0;
          state <= CONV;
        end
        CONV: begin
          if (cnt == CW'(RW)) begin
            disp  <= bcd_r;
            error <= err_r;
            zero  <= ~err_r & (bcd_r == '0);
            state <= DONE;
          end else begin
            bcd_r <= {bcd_adj[BW-2:0], bin_r[RW-1]};
            bin_r <= {bin_r[RW-2:0], 1'b0};
            cnt   <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CALC) || (state == CONV);
  assign done = (state == DONE);

  always_comb begin
    idx_next = idx;
    if (pre == PW'(DIV - 1)) begin
      idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  always_comb begin
    digit = disp[4*idx_next +: 4];
    if (error) seg_next = (idx_next == '0) ? SEG_E : SEG_BLANK;
    else       seg_next = decode(digit);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
      seg <= 7'b1111110;
    end else begin
      pre <= (pre == PW'(DIV - 1)) ? '0 : pre + PW'(1);
      idx <= idx_next;
      seg <= seg_next;
    end
  end

  always_comb begin
    select_disp      = '1;
    select_disp[idx] = 1'b0;
  end

endmodule

// File: tb/tb_alu_disp_scan.sv
// Bench for alu_disp_scan (WIDTH=4, DIGITS=4, DIV=4): table vectors, corner
// sequences and random operations against an arithmetic reference model.
module tb_alu_disp_scan;

  logic       mclk;
  logic       rst;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [1:0] op;
  logic       start;
  logic       busy;
  logic       done;
  logic       zero;
  logic       error;
  logic [3:0] select_disp;
  logic [6:0] seg;

  int vectors;
  int miscompares;

  logic [6:0] seg_code [10];
  localparam logic [6:0] SEG_E = 7'b1001111;

  typedef struct {
    int a;
    int b;
    int o;
    int val;
    int err;
  } vec_t;

  vec_t vecs [8];

  alu_disp_scan #(.WIDTH(4), .DIGITS(4), .DIV(4)) dut (
    .mclk(mclk), .rst(rst), .in1(in1), .in2(in2), .op(op), .start(start),
    .busy(busy), .done(done), .zero(zero), .error(error),
    .select_disp(select_disp), .seg(seg)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input int a, input int b, input int o,
                       output int val, output int err);
    err = 0;
    val = 0;
    case (o)
      0: val = a + b;
      1: if (a < b) err = 1; else val = a - b;
      2: val = a * b;
      default: if (b == 0) err = 1; else val = a / b;
    endcase
    if (val > 9999) err = 1;
    if (err != 0) val = 0;
  endtask

  // Watches one full scan period and compares each digit's pattern.
  task automatic check_display(input string tag, input int val, input int err);
    logic [6:0] got [4];
    bit         seen [4];
    int         bad_sel;
    int         zeros;
    int         pos;
    int         v;
    int         exp;
    bad_sel = 0;
    for (int d = 0; d < 4; d++) begin seen[d] = 0; got[d] = '0; end
    for (int c = 0; c < 16; c++) begin
      zeros = 0;
      pos = 0;
      for (int d = 0; d < 4; d++) if (select_disp[d] == 1'b0) begin zeros++; pos = d; end
      if (zeros != 1) bad_sel++;
      else begin got[pos] = seg; seen[pos] = 1; end
      tick();
    end
    check({tag, "_sel_onehot"}, bad_sel, 0);
    v = val;
    for (int d = 0; d < 4; d++) begin
      if (err != 0) exp = (d == 0) ? int'(SEG_E) : 0;
      else          exp = int'(seg_code[v % 10]);
      v = v / 10;
      check($sformatf("%s_seg_d%0d", tag, d), seen[d] ? int'(got[d]) : -1, exp);
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int o,
                        input int exp_val, input int exp_err);
    int lat;
    int bcnt;
    in1 = 4'(a);
    in2 = 4'(b);
    op  = 2'(o);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 10);
    check({tag, "_busy_cycles"}, bcnt, 10);
    check({tag, "_busy_in_done"}, int'(busy), 0);
    check({tag, "_error"}, int'(error), exp_err);
    check({tag, "_zero"}, int'(zero), (exp_err == 0 && exp_val == 0) ? 1 : 0);
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check_display(tag, exp_val, exp_err);
  endtask

  initial begin
    int mv;
    int me;
    int dcount;
    int a;
    int b;
    int o;
    vectors = 0;
    miscompares = 0;
    seg_code = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    vecs[0] = '{a: 9,  b: 7,  o: 0, val: 16,  err: 0};
    vecs[1] = '{a: 15, b: 15, o: 2, val: 225, err: 0};
    vecs[2] = '{a: 6,  b: 6,  o: 1, val: 0,   err: 0};
    vecs[3] = '{a: 3,  b: 5,  o: 1, val: 0,   err: 1};
    vecs[4] = '{a: 9,  b: 0,  o: 3, val: 0,   err: 1};
    vecs[5] = '{a: 15, b: 4,  o: 3, val: 3,   err: 0};
    vecs[6] = '{a: 15, b: 15, o: 0, val: 30,  err: 0};
    vecs[7] = '{a: 13, b: 1,  o: 2, val: 13,  err: 0};

    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; op = '0;
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_zero", int'(zero), 0);
    check("rst_error", int'(error), 0);
    check("rst_sel_0", int'(select_disp), 4'b1110);
    check("rst_seg_0", int'(seg), 7'b1111110);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("scan_sel_%0d", i), int'(select_disp),
            int'(4'hF & ~(4'b0001 << ((i / 4) % 4))));
      check($sformatf("scan_seg_%0d", i), int'(seg), 7'b1111110);
    end

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].o,
             vecs[i].val, vecs[i].err);
    end

    // start pulsed while busy must not restart or queue an operation
    in1 = 4'd9; in2 = 4'd7; op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    in1 = 4'd15; in2 = 4'd15; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    dcount = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) dcount++;
      tick();
    end
    check("busy_start_done_count", dcount, 1);
    check_display("busy_start", 16, 0);

    // reset in the middle of CONV discards the operation
    in1 = 4'd15; in2 = 4'd15; op = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("midconv_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midconv_busy_after_rst", int'(busy), 0);
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dcount++;
      tick();
    end
    check("midconv_no_done", dcount, 0);
    check("midconv_zero", int'(zero), 0);
    check("midconv_error", int'(error), 0);
    check_display("midconv", 0, 0);
    run_op("after_rst", 9, 7, 0, 16, 0);

    // start coinciding with reset is ignored
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_start_busy", int'(busy), 0);
    tick();
    check("rst_start_busy2", int'(busy), 0);

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      o = int'($urandom_range(0, 3));
      model(a, b, o, mv, me);
      run_op($sformatf("rnd%0d", i), a, b, o, mv, me);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_disp_scan.md
ALU_DISP_SCAN -- requirements
Module: alu_disp_scan

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits (2..8).
REQ-002 Parameter DIGITS, default 4: number of multiplexed 7-segment digits (1..4).
REQ-003 Parameter DIV, default 50000: mclk cycles each digit is held during scanning (>=2).
REQ-004 mclk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 in1  input  WIDTH  operand A, unsigned.
REQ-007 in2  input  WIDTH  operand B, unsigned.
REQ-008 op  input  2  opcode: 00 add, 01 sub (in1-in2), 10 mul, 11 div (integer quotient).
REQ-009 start  input  1  request: latch operands and compute.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when a new result reaches the display.
REQ-012 zero  output  1  last result equal to 0 and error clear.
REQ-013 error  output  1  last operation invalid or not displayable.
REQ-014 select_disp  output  DIGITS  digit enables, active-low, one-hot; bit 0 = least significant digit.
REQ-015 seg  output  7  segments, active-high; seg[6]=A ... seg[0]=G.

Function
REQ-016 FSM states IDLE, CALC, CONV, DONE; transitions occur only on the rising edge of mclk.
REQ-017 IDLE: start=1 latches in1, in2 and op, then moves to CALC; start is ignored in every other state.
REQ-018 CALC (1 cycle): registers a 2*WIDTH-bit result and the error flag, then moves to CONV.
REQ-019 Error conditions: sub with in1<in2; div with in2=0; result > 10^DIGITS-1. When error is set, the result is forced to 0.
REQ-020 CONV: sequential double-dabble, exactly one shift per cycle, 2*WIDTH cycles; each nibble >=5 gets +3 before the shift; then moves to DONE.
REQ-021 DONE (1 cycle): copies the BCD digits into the display registers, updates zero and error, and asserts done=1; then moves to IDLE.
REQ-022 busy=1 in CALC and CONV, 0 in IDLE and DONE.
REQ-023 Latency: start sampled at edge k gives done=1 in the cycle following edge k+2+2*WIDTH.
REQ-024 zero, error and the display registers hold their values between DONE states.
REQ-025 Scan prescaler counts 0..DIV-1 continuously, independent of the FSM; at wrap, the digit index increments and wraps from DIGITS-1 to 0.
REQ-026 select_disp drives low only the bit at the digit index; seg is the registered decode of that digit.
REQ-027 Decode, seg[6:0]: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-028 When error=1: digit 0 shows E (1001111) and all other digits are blank (0000000).
REQ-029 No leading-zero blanking: every digit shows its value.
REQ-030 Display registers update only in DONE, so no digit shows a partial result.

Reset
REQ-031 rst=1 in any state, including mid-CONV, sets the FSM to IDLE; the operation in flight is discarded with no done pulse.
REQ-032 Reset values: busy=0, done=0, zero=0, error=0, all display digits 0, prescaler 0, digit index 0, select_disp = all ones except bit 0, seg=1111110.
REQ-033 start asserted in the same cycle as rst is ignored.

Verification (WIDTH=4, DIGITS=4, DIV=4)
REQ-034 Reset, then idle 16 cycles -> select_disp steps 1110,1101,1011,0111, holding each for 4 cycles, then wraps to 1110; seg=1111110 throughout.
REQ-035 in1=9, in2=7, op=00, start at edge k -> busy for 10 cycles, done in the cycle after edge k+10, digits 0016, zero=0, error=0.
REQ-036 in1=15, in2=15, op=10 -> digits 0225; then in1=6, in2=6, op=01 -> digits 0000, zero=1.
REQ-037 op=01 with in1=3, in2=5; then op=11 with in2=0 -> error=1 both times, digit 0 shows 1001111, other digits blank, zero=0.
REQ-038 start pulsed while busy=1 -> ignored, with exactly one done; rst asserted mid-CONV -> no done, display returns to 0000, next start completes normally.
